// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshake; ALU_MC_MUL_EN enables the shift-add multiplier (op 14)
module alu_mc #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic [3:0]       flags
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DONE = 2'd2;
`ifdef ALU_MC_MUL_EN
  localparam logic [1:0] MUL = 2'd1;
  logic [2*WIDTH-1:0] p;
  logic [WIDTH-1:0]   mc;
  logic [WIDTH:0]     s;
  logic [6:0]         cnt;
`else
  localparam logic ILLEGAL_V = 1'b1;
`endif
  logic [1:0]       state;
  logic             cflag;
  logic             acc;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH-1:0] r;
  logic             rc, rv, rn, rz;
  assign in_ready  = reset_n && (state == IDLE || (state == DONE && out_ready));
  assign acc       = in_valid && in_ready;
  assign out_valid = state == DONE;
  // single-cycle result and flags for the op presented at the inputs
  always_comb begin
    sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, op == 4'd8 && cflag};
    dif = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, op == 4'd9 && cflag};
    r   = '0;
    rc  = 1'b0;
    rv  = 1'b0;
    case (op)
      4'd0, 4'd8: begin
        r  = sum[WIDTH-1:0];
        rc = sum[WIDTH];
        rv = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'd1, 4'd9, 4'd13: begin
        r  = op == 4'd13 ? a : dif[WIDTH-1:0];
        rc = dif[WIDTH];
        rv = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      4'd2:  begin r = {a[WIDTH-2:0], 1'b0};       rc = a[WIDTH-1]; end
      4'd3:  begin r = {a[0], a[WIDTH-1:1]};       rc = a[0];       end
      4'd4:  r = a & b;
      4'd5:  r = a | b;
      4'd6:  r = a ^ b;
      4'd7:  r = ~a;
      4'd10: begin r = {1'b0, a[WIDTH-1:1]};       rc = a[0];       end
      4'd11: begin r = {a[WIDTH-1], a[WIDTH-1:1]}; rc = a[0];       end
      4'd12: begin r = {a[WIDTH-2:0], a[WIDTH-1]}; rc = a[WIDTH-1]; end
      4'd14: begin
`ifdef ALU_MC_MUL_EN
        r = '0;
`else
        rv = ILLEGAL_V;
`endif
      end
      4'd15: r = b;
      default: r = '0;
    endcase
    rn = op == 4'd13 ? dif[WIDTH-1] : r[WIDTH-1];
    rz = op == 4'd13 ? a == b : r == '0;
  end
`ifdef ALU_MC_MUL_EN
  // one shift-add step: add multiplicand into the high half when the current multiplier bit is set
  always_comb s = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, mc} : '0);
`endif
  // FSM, result registers and carry flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      y     <= '0;
      y_hi  <= '0;
      flags <= '0;
      cflag <= 1'b0;
`ifdef ALU_MC_MUL_EN
      p     <= '0;
      mc    <= '0;
      cnt   <= '0;
`endif
    end else if (acc) begin
`ifdef ALU_MC_MUL_EN
      if (op == 4'd14) begin
        state <= MUL;
        p     <= {{WIDTH{1'b0}}, b};
        mc    <= a;
        cnt   <= '0;
      end else begin
`else
      begin
`endif
        state <= DONE;
        y     <= r;
        y_hi  <= '0;
        flags <= {rn, rv, rc, rz};
        cflag <= op == 4'd14 ? cflag : rc;
      end
    end
`ifdef ALU_MC_MUL_EN
    else if (state == MUL) begin
      if (cnt == 7'(WIDTH)) begin
        state <= DONE;
        y     <= p[WIDTH-1:0];
        y_hi  <= p[2*WIDTH-1:WIDTH];
        flags <= {p[WIDTH-1], 1'b0, |p[2*WIDTH-1:WIDTH], p == '0};
        cflag <= |p[2*WIDTH-1:WIDTH];
      end else begin
        p   <= {s, p[WIDTH-1:1]};
        cnt <= cnt + 7'd1;
      end
    end
`endif
    else if (state == DONE && out_ready) state <= IDLE;
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc at WIDTH=16
module tb_alu_mc;
  logic        clk = 1'b0;
  logic        reset_n, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  op, flags;
  logic [15:0] a, b, y, y_hi;
  int checks = 0;
  int errors = 0;
  logic [3:0]  t_op [12] = '{4'd2, 4'd10, 4'd12, 4'd4, 4'd5, 4'd6, 4'd7, 4'd15, 4'd1, 4'd9, 4'd0, 4'd8};
  logic [15:0] t_a  [12] = '{16'h8001, 16'h8001, 16'h8001, 16'hF0F0, 16'h0F00, 16'hAAAA, 16'h0000, 16'h0000, 16'h0000, 16'h0005, 16'h7FFF, 16'h0001};
  logic [15:0] t_b  [12] = '{16'h0000, 16'h0000, 16'h0000, 16'hFF00, 16'h00F0, 16'hAAAA, 16'h0000, 16'h8000, 16'h0001, 16'h0002, 16'h0001, 16'h0001};
  logic [15:0] t_y  [12] = '{16'h0002, 16'h4000, 16'h0003, 16'hF000, 16'h0FF0, 16'h0000, 16'hFFFF, 16'h8000, 16'hFFFF, 16'h0002, 16'h8000, 16'h0002};
  logic [3:0]  t_f  [12] = '{4'h2, 4'h2, 4'h2, 4'h8, 4'h0, 4'h1, 4'h8, 4'h8, 4'hA, 4'h0, 4'hC, 4'h0};

  alu_mc #(.WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .y_hi(y_hi), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [15:0] x, input logic [15:0] z);
    op = o; a = x; b = z; in_valid = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 4'd0; a = '0; b = '0;
    step(); step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if ({y, y_hi, flags} !== 36'h0) begin errors++; $display("FAIL reset_outputs got %h %h %h want 0", y, y_hi, flags); end
    reset_n = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_add_adc;
    drive(4'd0, 16'hFFFF, 16'h0001);
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_latency got %b want 1", out_valid); end
    checks++; if (y !== 16'h0000 || flags !== 4'b0011) begin errors++; $display("FAIL add got y=%h f=%b want 0000 0011", y, flags); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL done_in_ready got %b want 1", in_ready); end
    drive(4'd8, 16'h0001, 16'h0001);
    step();
    checks++; if (y !== 16'h0003 || flags !== 4'b0000) begin errors++; $display("FAIL adc_b2b got y=%h f=%b want 0003 0000", y, flags); end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_idle got %b want 0", out_valid); end
  endtask

  task automatic test_sub_cmp;
    drive(4'd1, 16'h8000, 16'h0001);
    step();
    checks++; if (y !== 16'h7FFF || flags !== 4'b0100) begin errors++; $display("FAIL sub got y=%h f=%b want 7fff 0100", y, flags); end
    drive(4'd13, 16'h0005, 16'h0005);
    step();
    checks++; if (y !== 16'h0005 || flags !== 4'b0001) begin errors++; $display("FAIL cmp got y=%h f=%b want 0005 0001", y, flags); end
    drive(4'd13, 16'h0003, 16'h0005);
    step();
    checks++; if (y !== 16'h0003 || flags !== 4'b1010) begin errors++; $display("FAIL cmp_lt got y=%h f=%b want 0003 1010", y, flags); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_shifts;
    drive(4'd3, 16'h0001, 16'h0000);
    step();
    checks++; if (y !== 16'h8000 || flags !== 4'b1010) begin errors++; $display("FAIL ror got y=%h f=%b want 8000 1010", y, flags); end
    drive(4'd11, 16'h8002, 16'h0000);
    step();
    checks++; if (y !== 16'hC001 || flags !== 4'b1000) begin errors++; $display("FAIL asr got y=%h f=%b want c001 1000", y, flags); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_ops;
    for (int i = 0; i < 12; i++) begin
      drive(t_op[i], t_a[i], t_b[i]);
      step();
      checks++; if (out_valid !== 1'b1 || y !== t_y[i] || flags !== t_f[i]) begin errors++; $display("FAIL op_table[%0d] got v=%b y=%h f=%b want 1 %h %b", i, out_valid, y, flags, t_y[i], t_f[i]); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL op_table_idle got %b want 0", out_valid); end
  endtask

  task automatic test_mul;
`ifdef ALU_MC_MUL_EN
    int k;
    logic busy_ready;
    busy_ready = 1'b0;
    drive(4'd14, 16'h1234, 16'h0100);
    step();
    in_valid = 1'b0;
    k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      busy_ready |= in_ready;
      step();
      if (out_valid) k = i;
    end
    checks++; if (k !== 17) begin errors++; $display("FAIL mul_latency got %0d want 17", k); end
    checks++; if (busy_ready !== 1'b0) begin errors++; $display("FAIL mul_in_ready got %b want 0", busy_ready); end
    checks++; if (y !== 16'h3400 || y_hi !== 16'h0012 || flags !== 4'b0010) begin errors++; $display("FAIL mul got y=%h hi=%h f=%b want 3400 0012 0010", y, y_hi, flags); end
    step();
`else
    drive(4'd0, 16'hFFFF, 16'h0001);
    step();
    drive(4'd14, 16'h1234, 16'h0100);
    step();
    checks++; if (out_valid !== 1'b1 || y !== 16'h0000 || y_hi !== 16'h0000 || flags !== 4'b0101) begin errors++; $display("FAIL op14 got v=%b y=%h hi=%h f=%b want 1 0000 0000 0101", out_valid, y, y_hi, flags); end
    drive(4'd8, 16'h0001, 16'h0001);
    step();
    checks++; if (y !== 16'h0003) begin errors++; $display("FAIL op14_cflag got y=%h want 0003", y); end
    in_valid = 1'b0;
    step();
`endif
  endtask

  task automatic test_stall;
    out_ready = 1'b0;
    drive(4'd0, 16'h0003, 16'h0004);
    step();
    drive(4'd1, 16'h0009, 16'h0001);
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || y !== 16'h0007 || flags !== 4'b0000) begin errors++; $display("FAIL stall[%0d] got v=%b rdy=%b y=%h f=%b want 1 0 0007 0000", i, out_valid, in_ready, y, flags); end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b want 1", in_ready); end
    step();
    checks++; if (y !== 16'h0008) begin errors++; $display("FAIL stall_accept got y=%h want 0008", y); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_op;
    logic seen;
    seen = 1'b0;
    drive(4'd0, 16'hFFFF, 16'h0001);
    step();
    in_valid = 1'b0;
    step();
`ifdef ALU_MC_MUL_EN
    drive(4'd14, 16'h1234, 16'h0100);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      seen |= out_valid;
    end
    reset_n = 1'b0;
`else
    drive(4'd0, 16'h0001, 16'h0001);
    reset_n = 1'b0;
`endif
    step();
    seen |= out_valid;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_mid_ready got %b want 0", in_ready); end
    reset_n = 1'b1;
    in_valid = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_release got %b want 1", in_ready); end
    for (int i = 0; i < 20; i++) begin
      seen |= out_valid;
      step();
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_mid_output got %b want 0", seen); end
    drive(4'd8, 16'h0001, 16'h0001);
    step();
    checks++; if (y !== 16'h0002 || flags !== 4'b0000) begin errors++; $display("FAIL reset_adc got y=%h f=%b want 0002 0000", y, flags); end
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_add_adc();
    test_sub_cmp();
    test_shifts();
    test_ops();
    test_mul();
    test_stall();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
